// File: rtl/score_bcd_converter.sv
// Serial double-dabble converter: binary score to registered BCD digits, one bit per clock.
// Optional high-score tracking is enabled by defining HISCORE_TRACK_EN.
module score_bcd_converter #(
   parameter int SCORE_W = 10,
   parameter int DIGITS  = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [SCORE_W-1:0]    score,
   output logic [4*DIGITS-1:0]   bcd_digits,
   output logic                  bcd_valid,
   output logic                  busy
`ifdef HISCORE_TRACK_EN
   ,
   output logic [4*DIGITS-1:0]   hiscore_digits,
   output logic                  new_hiscore
`endif
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int W     = BCD_W + SCORE_W;
   localparam int CNT_W = (SCORE_W > 1) ? $clog2(SCORE_W) : 1;

   function automatic longint pow10(input int n);
      longint r;
      r = 1;
      for (int i = 0; i < n; i++) r = r * 10;
      return r;
   endfunction

   generate
      if (pow10(DIGITS) <= ((longint'(1) << SCORE_W) - 1)) begin : g_range_err
         $error("score_bcd_converter: DIGITS too small for SCORE_W");
      end
   endgenerate

   // Pre-shift correction: every nibble >= 5 gets +3 so the next doubling carries correctly.
   function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
      logic [BCD_W-1:0] r;
      r = b;
      for (int i = 0; i < DIGITS; i++) begin
         if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
      end
      return r;
   endfunction

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t             state_q, state_d;
   logic [W-1:0]       work_q, work_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [SCORE_W-1:0] last_q, last_d;
   logic [BCD_W-1:0]   digits_q, digits_d;
   logic               valid_q, valid_d;
   logic               busy_q, busy_d;
`ifdef HISCORE_TRACK_EN
   logic [SCORE_W-1:0] hi_q, hi_d;
   logic [BCD_W-1:0]   hidig_q, hidig_d;
   logic               newhi_q, newhi_d;
`endif

   logic [BCD_W-1:0]   adj_bcd;
   logic [W-1:0]       shift_w;

   assign adj_bcd = add3(work_q[W-1:SCORE_W]);
   assign shift_w = {adj_bcd, work_q[SCORE_W-1:0]} << 1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         work_q   <= '0;
         cnt_q    <= '0;
         last_q   <= '0;
         digits_q <= '0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
`ifdef HISCORE_TRACK_EN
         hi_q     <= '0;
         hidig_q  <= '0;
         newhi_q  <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         work_q   <= work_d;
         cnt_q    <= cnt_d;
         last_q   <= last_d;
         digits_q <= digits_d;
         valid_q  <= valid_d;
         busy_q   <= busy_d;
`ifdef HISCORE_TRACK_EN
         hi_q     <= hi_d;
         hidig_q  <= hidig_d;
         newhi_q  <= newhi_d;
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      work_d   = work_q;
      cnt_d    = cnt_q;
      last_d   = last_q;
      digits_d = digits_q;
      valid_d  = 1'b0;
      busy_d   = busy_q;
`ifdef HISCORE_TRACK_EN
      hi_d     = hi_q;
      hidig_d  = hidig_q;
      newhi_d  = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (score != last_q) begin
               work_d  = {{BCD_W{1'b0}}, score};
               last_d  = score;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            work_d = shift_w;
            cnt_d  = cnt_q + CNT_W'(1);
            // Last bit shifted in: publish the finished digits only now, never partials.
            if (cnt_q == CNT_W'(SCORE_W - 1)) begin
               digits_d = shift_w[W-1:SCORE_W];
               valid_d  = 1'b1;
               busy_d   = 1'b0;
               state_d  = IDLE;
`ifdef HISCORE_TRACK_EN
               if (last_q > hi_q) begin
                  hi_d    = last_q;
                  hidig_d = shift_w[W-1:SCORE_W];
                  newhi_d = 1'b1;
               end
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bcd_digits = digits_q;
   assign bcd_valid  = valid_q;
   assign busy       = busy_q;
`ifdef HISCORE_TRACK_EN
   assign hiscore_digits = hidig_q;
   assign new_hiscore    = newhi_q;
`endif

endmodule

// File: tb/tb_score_bcd_converter.sv
// Randomized and directed bench for score_bcd_converter against a decimal-arithmetic reference model.
module tb_score_bcd_converter;
   localparam int SCORE_W = 10;
   localparam int DIGITS  = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [9:0]  score;
   logic [15:0] bcd_digits;
   logic        bcd_valid;
   logic        busy;
`ifdef HISCORE_TRACK_EN
   logic [15:0] hiscore_digits;
   logic        new_hiscore;
`endif

   int n_cmp = 0;
   int n_mis = 0;

   int          m_last, m_conv, m_left, m_hi;
   logic [15:0] m_digits, m_hidig;
   logic        m_valid, m_newhi;
   int          hi_pulses;

   score_bcd_converter #(.SCORE_W(SCORE_W), .DIGITS(DIGITS)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .score          (score),
      .bcd_digits     (bcd_digits),
      .bcd_valid      (bcd_valid),
      .busy           (busy)
`ifdef HISCORE_TRACK_EN
      ,
      .hiscore_digits (hiscore_digits),
      .new_hiscore    (new_hiscore)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r;
      int          x;
      r = '0;
      x = v;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   task automatic model_reset();
      m_last = 0; m_conv = 0; m_left = 0; m_hi = 0;
      m_digits = '0; m_hidig = '0; m_valid = 1'b0; m_newhi = 1'b0;
   endtask

   // A conversion occupies SCORE_W cycles after load; result appears when the count runs out.
   task automatic model_step();
      if (!rst_n) begin
         model_reset();
      end else begin
         m_valid = 1'b0;
         m_newhi = 1'b0;
         if (m_left == 0) begin
            if (int'(score) != m_last) begin
               m_last = int'(score);
               m_conv = int'(score);
               m_left = SCORE_W;
            end
         end else begin
            m_left--;
            if (m_left == 0) begin
               m_digits = to_bcd(m_conv);
               m_valid  = 1'b1;
               if (m_conv > m_hi) begin
                  m_hi    = m_conv;
                  m_hidig = to_bcd(m_conv);
                  m_newhi = 1'b1;
               end
            end
         end
      end
   endtask

   task automatic compare_all();
      chk("digits", 32'(bcd_digits), 32'(m_digits));
      chk("valid",  32'(bcd_valid),  32'(m_valid));
      chk("busy",   32'(busy),       32'(m_left != 0));
`ifdef HISCORE_TRACK_EN
      chk("hidig",  32'(hiscore_digits), 32'(m_hidig));
      chk("newhi",  32'(new_hiscore),    32'(m_newhi));
      if (new_hiscore) hi_pulses++;
`endif
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all();
   endtask

   initial begin
      rst_n = 1'b0;
      score = '0;
      hi_pulses = 0;
      model_reset();
      cycle();
      cycle();
      chk("rst_digits", 32'(bcd_digits), 32'h0);
      chk("rst_busy",   32'(busy),       32'h0);
      rst_n = 1'b1;

      repeat (20) cycle();

      score = 10'd1023;
      repeat (12) cycle();
      chk("d1023", 32'(bcd_digits), 32'h1023);

      score = 10'd123;
      repeat (4) cycle();
      score = 10'd456;
      repeat (12) cycle();
      chk("d0123", 32'(bcd_digits), 32'h0123);
      repeat (12) cycle();
      chk("d0456", 32'(bcd_digits), 32'h0456);

      score = 10'd1023;
      repeat (12) cycle();
      score = 10'd0;
      repeat (12) cycle();
      chk("wrap0", 32'(bcd_digits), 32'h0);

      score = 10'd789;
      cycle();
      repeat (5) cycle();
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("abort_digits", 32'(bcd_digits), 32'h0);
      chk("abort_busy",   32'(busy),       32'h0);
      chk("abort_valid",  32'(bcd_valid),  32'h0);
      cycle();
      cycle();
      rst_n = 1'b1;
      repeat (12) cycle();
      chk("d0789", 32'(bcd_digits), 32'h0789);

`ifdef HISCORE_TRACK_EN
      rst_n = 1'b0;
      cycle();
      rst_n = 1'b1;
      hi_pulses = 0;
      score = 10'd50; repeat (13) cycle();
      score = 10'd30; repeat (13) cycle();
      score = 10'd70; repeat (13) cycle();
      chk("hi_pulses", 32'(hi_pulses), 32'd2);
      chk("hi_final",  32'(hiscore_digits), 32'h0070);
`endif

      for (int i = 0; i < 3000; i++) begin
         rst_n = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
         if ($urandom_range(0, 5) == 0) begin
            if ($urandom_range(0, 3) == 0) score = 10'(m_last);
            else score = 10'($urandom_range(0, 1023));
         end
         cycle();
      end
      rst_n = 1'b1;
      repeat (15) cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
